// File: rtl/skeleton_frame_scheduler.sv
// ----------------------------------------------------------------------------
// skeleton_frame_scheduler
//
// Frame-level admission controller in front of the skeletonizer. Exactly one
// complete camera frame is forwarded into the skeletonizer at a time. Pixel
// writes are blocked while the skeletonizer is thinning or outputting, and
// frames that start during that window are counted as dropped. A watchdog
// pulses a recovery reset into the skeletonizer if it stays busy too long.
//
// Ports:
//   clk_in, rst_in            single clock, asynchronous active-high reset
//   enable_in                 permits frame admission (sampled in IDLE and at
//                             completion / recovery exit only)
//   hcount_in, vcount_in      camera column / row
//   pixel_in, pixel_valid_in  camera binary pixel and its strobe
//   sk_hcount_out, sk_vcount_out, sk_pixel_out
//                             registered camera stream to the skeletonizer
//   sk_pixel_valid_out        registered, gated strobe to the skeletonizer
//   sk_busy_in                skeletonizer busy flag
//   sk_rst_out                registered recovery reset to the skeletonizer
//   frame_done_out            one-cycle pulse per completed frame
//   frames_accepted_out       saturating count of completed frames
//   frames_dropped_out        saturating count of dropped frames
//   timeouts_out              saturating count of watchdog trips
//   state_out                 registered FSM state encoding
// ----------------------------------------------------------------------------
module skeleton_frame_scheduler #(
    parameter int unsigned HORIZONTAL_COUNT = 320,
    parameter int unsigned VERTICAL_COUNT   = 180,
    parameter int unsigned TIMEOUT_CYCLES   = 2_000_000,
    parameter int unsigned RECOVER_CYCLES   = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                enable_in,
    input  logic [$clog2(HORIZONTAL_COUNT)-1:0] hcount_in,
    input  logic [$clog2(VERTICAL_COUNT)-1:0]   vcount_in,
    input  logic                                pixel_in,
    input  logic                                pixel_valid_in,
    output logic [$clog2(HORIZONTAL_COUNT)-1:0] sk_hcount_out,
    output logic [$clog2(VERTICAL_COUNT)-1:0]   sk_vcount_out,
    output logic                                sk_pixel_out,
    output logic                                sk_pixel_valid_out,
    input  logic                                sk_busy_in,
    output logic                                sk_rst_out,
    output logic                                frame_done_out,
    output logic [15:0]                         frames_accepted_out,
    output logic [15:0]                         frames_dropped_out,
    output logic [7:0]                          timeouts_out,
    output logic [2:0]                          state_out
);

    localparam int HW  = $clog2(HORIZONTAL_COUNT);
    localparam int VW  = $clog2(VERTICAL_COUNT);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RCW = $clog2(RECOVER_CYCLES + 1);

    localparam logic [HW-1:0]  H_LAST  = HW'(HORIZONTAL_COUNT - 1);
    localparam logic [VW-1:0]  V_LAST  = VW'(VERTICAL_COUNT - 1);
    // The trip fires on the edge where the watchdog count would reach
    // TIMEOUT_CYCLES, so compare against the value one below it.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SOF  = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_PROCESS   = 3'd4,
        ST_RECOVER   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [WDW-1:0] wd_q;
    logic [RCW-1:0] rc_q;

    logic sof, eof;
    logic fwd;        // forward the current pixel into the skeletonizer
    logic wd_clear;   // entering WAIT_BUSY
    logic wd_inc;     // watchdog running
    logic complete;   // PROCESS saw busy fall
    logic trip;       // watchdog expired
    logic drop;       // SOF arrived while the skeletonizer owns the buffer

    assign sof = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign eof = pixel_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);

    assign drop = sof && ((state_q == ST_WAIT_BUSY) ||
                          (state_q == ST_PROCESS)   ||
                          (state_q == ST_RECOVER));

    assign state_out = state_q;

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        fwd      = 1'b0;
        wd_clear = 1'b0;
        wd_inc   = 1'b0;
        complete = 1'b0;
        trip     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_in) state_d = ST_WAIT_SOF;
            end

            ST_WAIT_SOF: begin
                if (sof) begin
                    fwd     = 1'b1;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // A fresh SOF here simply restarts the frame in place; the
                // skeletonizer addresses its buffer by coordinates.
                fwd = pixel_valid_in;
                if (eof) begin
                    state_d  = ST_WAIT_BUSY;
                    wd_clear = 1'b1;
                end
            end

            ST_WAIT_BUSY: begin
                wd_inc = 1'b1;
                if (wd_q == WD_LAST) begin
                    trip    = 1'b1;
                    state_d = ST_RECOVER;
                end else if (sk_busy_in) begin
                    state_d = ST_PROCESS;
                end
            end

            ST_PROCESS: begin
                wd_inc = 1'b1;
                // Completion is checked first so that busy falling on the
                // very cycle the watchdog expires counts as success.
                if (!sk_busy_in) begin
                    complete = 1'b1;
                    state_d  = enable_in ? ST_WAIT_SOF : ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    trip    = 1'b1;
                    state_d = ST_RECOVER;
                end
            end

            ST_RECOVER: begin
                if (rc_q == RC_LAST) state_d = enable_in ? ST_WAIT_SOF : ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, watchdog and recovery timers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            rc_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;

            if (wd_clear)    wd_q <= '0;
            else if (wd_inc) wd_q <= wd_q + 1'b1;

            // Counts cycles already spent in RECOVER; zero on entry.
            if ((state_q == ST_RECOVER) && (state_d == ST_RECOVER)) rc_q <= rc_q + 1'b1;
            else                                                    rc_q <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: the forward-path registers are reset too, because the
            // skeletonizer must see a clean, all-zero interface while the
            // system reset is asserted.
            sk_hcount_out       <= '0;
            sk_vcount_out       <= '0;
            sk_pixel_out        <= 1'b0;
            sk_pixel_valid_out  <= 1'b0;
            sk_rst_out          <= 1'b0;
            frame_done_out      <= 1'b0;
            frames_accepted_out <= '0;
            frames_dropped_out  <= '0;
            timeouts_out        <= '0;
        end else begin
            // Coordinates and data pass through every cycle; only the strobe
            // is gated, since the frame buffer writes on every valid pixel.
            sk_hcount_out      <= hcount_in;
            sk_vcount_out      <= vcount_in;
            sk_pixel_out       <= pixel_in;
            sk_pixel_valid_out <= fwd;

            sk_rst_out     <= (state_d == ST_RECOVER);
            frame_done_out <= complete;

            if (complete && (frames_accepted_out != '1)) frames_accepted_out <= frames_accepted_out + 1'b1;
            if (drop && (frames_dropped_out != '1))      frames_dropped_out  <= frames_dropped_out + 1'b1;
            if (trip && (timeouts_out != '1))            timeouts_out        <= timeouts_out + 1'b1;
        end
    end

endmodule

// File: doc/skeleton_frame_scheduler.md
# skeleton_frame_scheduler

Frame-level controller in front of the `skeletonizer` block. It admits exactly one complete camera frame at a time into the skeletonizer. It blocks pixel writes while the skeletonizer is thinning or outputting, and counts frames dropped in that window. A watchdog pulses a reset into the skeletonizer if it stays busy too long.

## Interface
Parameters:
- `HORIZONTAL_COUNT`, 320, pixels per line; must match the skeletonizer.
- `VERTICAL_COUNT`, 180, lines per frame; must match the skeletonizer.
- `TIMEOUT_CYCLES`, 2_000_000, maximum cycles from end of load to skeletonizer idle.
- `RECOVER_CYCLES`, 4, length of the `sk_rst_out` pulse, ≥1.

Ports (HW = $clog2(HORIZONTAL_COUNT), VW = $clog2(VERTICAL_COUNT)):
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `enable_in` in 1: permits frame admission.
- `hcount_in` in HW: camera column.
- `vcount_in` in VW: camera row.
- `pixel_in` in 1: camera binary pixel.
- `pixel_valid_in` in 1: camera pixel strobe.
- `sk_hcount_out` out HW: registered column to the skeletonizer.
- `sk_vcount_out` out VW: registered row to the skeletonizer.
- `sk_pixel_out` out 1: registered pixel to the skeletonizer.
- `sk_pixel_valid_out` out 1: gated, registered strobe to the skeletonizer.
- `sk_busy_in` in 1: skeletonizer `busy`.
- `sk_rst_out` out 1: registered recovery reset to the skeletonizer, OR'd externally with the system reset.
- `frame_done_out` out 1: one-cycle pulse when a frame finishes processing.
- `frames_accepted_out` out 16: saturating count of frames completed.
- `frames_dropped_out` out 16: saturating count of dropped frames.
- `timeouts_out` out 8: saturating count of watchdog trips.
- `state_out` out 3: current state encoding.

## Operation
- States and encodings:
  - IDLE = 0.
  - WAIT_SOF = 1.
  - LOAD = 2.
  - WAIT_BUSY = 3.
  - PROCESS = 4.
  - RECOVER = 5.
- SOF means `pixel_valid_in` with h=0, v=0. EOF means `pixel_valid_in` with h=HORIZONTAL_COUNT-1, v=VERTICAL_COUNT-1.
- IDLE: if `enable_in` is high, go to WAIT_SOF.
- WAIT_SOF: on SOF, forward that pixel and go to LOAD. All other pixels are discarded.
- LOAD:
  - Forward every valid pixel.
  - On EOF, forward it and go to WAIT_BUSY.
  - An SOF arriving in LOAD restarts the load in place; no counter changes.
- WAIT_BUSY: on `sk_busy_in`=1, go to PROCESS.
- PROCESS: on `sk_busy_in`=0:
  - Pulse `frame_done_out` and increment `frames_accepted_out`.
  - Go to WAIT_SOF if `enable_in` is high, else IDLE.
- Watchdog:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_BUSY.
  - It increments every cycle in WAIT_BUSY and PROCESS.
  - When it reaches TIMEOUT_CYCLES: increment `timeouts_out` and go to RECOVER.
- RECOVER:
  - `sk_rst_out`=1 for exactly RECOVER_CYCLES cycles.
  - Then go to WAIT_SOF if `enable_in` is high, else IDLE.
- Dropped frames: any SOF seen in WAIT_BUSY, PROCESS or RECOVER increments `frames_dropped_out`.
- Pixel gating: `sk_pixel_valid_out` is high only for pixels forwarded in WAIT_SOF/LOAD as above.
  - Rationale: the skeletonizer frame buffer accepts a write on every valid pixel, even while it is busy.
  - Coordinates and pixel data are forwarded every cycle regardless of gating.
- `enable_in` is sampled only in IDLE and at completion or recovery exit. Deasserting it mid-LOAD or mid-PROCESS does not abort the frame.
- All counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous): state IDLE; all outputs 0; watchdog counter 0.
- Forward path: 1-cycle latency. A pixel at cycle n appears on the `sk_*` outputs at n+1.
- State transitions take effect on the clock edge after the triggering input. `state_out` shows the registered state.
- `frame_done_out`: high for 1 cycle, on the cycle after the edge where PROCESS sees `sk_busy_in`=0. The counter updates on the same edge.
- Simultaneous events:
  - Busy falling on the same cycle the watchdog reaches TIMEOUT_CYCLES: completion wins; no timeout is counted.
  - SOF on the completion edge with `enable_in`=1: counted as dropped and not forwarded; admission starts at the next SOF.
- `sk_rst_out` first goes high on the cycle after the RECOVER entry edge.
- If `rst_in` asserts mid-frame, outputs clear immediately. After release, the block waits in IDLE, then for a fresh SOF.

## Test plan
Bench parameters: H=8, V=4, TIMEOUT=100, RECOVER=4.
- **Normal frame:** enable, stream a full frame, model busy high 2 cycles after EOF for 50 cycles → 32 forwarded valids, each 1 cycle late; `frame_done_out` one pulse; accepted=1, dropped=0.
- **Mid-frame start:** enable asserted at pixel (3,2) → nothing forwarded until the next SOF, then exactly 32 forwarded valids.
- **Busy overlap:** second frame streamed while busy is high → zero forwarded valids during busy; dropped=1; the third frame is admitted normally.
- **Watchdog:** busy held high forever → RECOVER at 100 cycles after WAIT_BUSY entry; `sk_rst_out` high for 4 cycles; timeouts=1; next frame admitted.
- **Tie:** busy drops exactly on the cycle the count hits 100 → `frame_done_out` pulses, timeouts=0.
- **Reset:** async reset asserted mid-LOAD → all outputs 0 without a clock edge; state IDLE after release.
